// File: rtl/regfile_wb_pkg.sv
// Shared register-file constants for the writeback-side register file and its load scoreboard.
package regfile_wb_pkg;

   localparam int unsigned RegBus     = 32;
   localparam int unsigned RegAddrBus = 5;
   localparam int unsigned RegNum     = 32;

   localparam logic [RegBus-1:0]     ZeroWord   = '0;
   localparam logic [RegAddrBus-1:0] NopRegAddr = '0;

   localparam logic RstEnable    = 1'b1;
   localparam logic WriteEnable  = 1'b1;
   localparam logic WriteDisable = 1'b0;
   localparam logic ReadEnable   = 1'b1;
   localparam logic ReadDisable  = 1'b0;

endpackage

// File: rtl/regfile_wb_ld_scoreboard.sv
// Busy bit per register for in-flight loads; raises a load-use stall toward ID.
module regfile_wb_ld_scoreboard
   import regfile_wb_pkg::*;
#(
   parameter int unsigned ADDR_W = RegAddrBus,
   parameter int unsigned NREGS  = RegNum
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wb_wreg,
   input  logic [ADDR_W-1:0] wb_wd,
   input  logic              ld_issue,
   input  logic [ADDR_W-1:0] ld_rd,
   input  logic              re1,
   input  logic [ADDR_W-1:0] raddr1,
   input  logic              re2,
   input  logic [ADDR_W-1:0] raddr2,
   output logic              stall_req
);

   logic [NREGS-1:0] busy_q, busy_d;
   logic             wb_en;
   logic             hazard1, hazard2;

   assign wb_en = (wb_wreg == WriteEnable) && (wb_wd != ADDR_W'(NopRegAddr));

   always_comb begin
      busy_d = busy_q;
      if (wb_en) busy_d[wb_wd] = 1'b0;
      // Applied after the clear so a new load to the same index stays pending.
      if (ld_issue && (ld_rd != ADDR_W'(NopRegAddr))) busy_d[ld_rd] = 1'b1;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst == RstEnable) busy_q <= '0;
      else                  busy_q <= busy_d;
   end

   // A read satisfied by this cycle's writeback bypass does not need to wait.
   always_comb begin
      hazard1 = (re1 == ReadEnable) && (raddr1 != ADDR_W'(NopRegAddr)) && busy_q[raddr1] &&
                !((wb_wreg == WriteEnable) && (wb_wd == raddr1));
      hazard2 = (re2 == ReadEnable) && (raddr2 != ADDR_W'(NopRegAddr)) && busy_q[raddr2] &&
                !((wb_wreg == WriteEnable) && (wb_wd == raddr2));
      stall_req = (rst != RstEnable) && (hazard1 || hazard2);
   end

endmodule

// File: rtl/regfile_wb.sv
// Architectural register file at the writeback end: one write port, two bypassed read ports.
module regfile_wb
   import regfile_wb_pkg::*;
#(
   parameter int unsigned DATA_W = RegBus,
   parameter int unsigned ADDR_W = RegAddrBus,
   parameter int unsigned NREGS  = RegNum
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wb_wreg,
   input  logic [ADDR_W-1:0] wb_wd,
   input  logic [DATA_W-1:0] wb_wdata,
   input  logic              re1,
   input  logic [ADDR_W-1:0] raddr1,
   output logic [DATA_W-1:0] rdata1,
   input  logic              re2,
   input  logic [ADDR_W-1:0] raddr2,
   output logic [DATA_W-1:0] rdata2,
   input  logic              ld_issue,
   input  logic [ADDR_W-1:0] ld_rd,
   output logic              stall_req
);

   logic [DATA_W-1:0] regs_q [NREGS];

   // Entry 0 is reset and never written, so x0 reads zero even without the read-side guard.
   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         for (int i = 0; i < int'(NREGS); i++) regs_q[i] <= DATA_W'(ZeroWord);
      end else if ((wb_wreg == WriteEnable) && (wb_wd != ADDR_W'(NopRegAddr))) begin
         regs_q[wb_wd] <= wb_wdata;
      end
   end

   always_comb begin
      rdata1 = DATA_W'(ZeroWord);
      if ((rst != RstEnable) && (re1 == ReadEnable) && (raddr1 != ADDR_W'(NopRegAddr))) begin
         if ((wb_wreg == WriteEnable) && (wb_wd == raddr1)) rdata1 = wb_wdata;
         else                                               rdata1 = regs_q[raddr1];
      end
   end

   always_comb begin
      rdata2 = DATA_W'(ZeroWord);
      if ((rst != RstEnable) && (re2 == ReadEnable) && (raddr2 != ADDR_W'(NopRegAddr))) begin
         if ((wb_wreg == WriteEnable) && (wb_wd == raddr2)) rdata2 = wb_wdata;
         else                                               rdata2 = regs_q[raddr2];
      end
   end

   regfile_wb_ld_scoreboard #(
      .ADDR_W (ADDR_W),
      .NREGS  (NREGS)
   ) u_ld_scoreboard (
      .clk       (clk),
      .rst       (rst),
      .wb_wreg   (wb_wreg),
      .wb_wd     (wb_wd),
      .ld_issue  (ld_issue),
      .ld_rd     (ld_rd),
      .re1       (re1),
      .raddr1    (raddr1),
      .re2       (re2),
      .raddr2    (raddr2),
      .stall_req (stall_req)
   );

endmodule

// File: tb/tb_regfile_wb.sv
// Directed bench for regfile_wb: a per-cycle reference model plus literal spot checks.
module tb_regfile_wb;

   logic        clk = 1'b0;
   logic        rst;
   logic        wb_wreg;
   logic [4:0]  wb_wd;
   logic [31:0] wb_wdata;
   logic        re1, re2;
   logic [4:0]  raddr1, raddr2;
   logic [31:0] rdata1, rdata2;
   logic        ld_issue;
   logic [4:0]  ld_rd;
   logic        stall_req;

   int unsigned n_total = 0;
   int unsigned n_pass  = 0;

   logic [31:0] m_regs [32];
   bit          m_busy [32];
   bit          m_valid = 1'b0;

   always #5 clk = ~clk;

   regfile_wb dut (
      .clk       (clk),
      .rst       (rst),
      .wb_wreg   (wb_wreg),
      .wb_wd     (wb_wd),
      .wb_wdata  (wb_wdata),
      .re1       (re1),
      .raddr1    (raddr1),
      .rdata1    (rdata1),
      .re2       (re2),
      .raddr2    (raddr2),
      .rdata2    (rdata2),
      .ld_issue  (ld_issue),
      .ld_rd     (ld_rd),
      .stall_req (stall_req)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Reference model state: what the architectural registers and pending loads are.
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) begin
            m_regs[i] <= 32'h0;
            m_busy[i] <= 1'b0;
         end
         m_valid <= 1'b1;
      end else begin
         if (wb_wreg && wb_wd != 5'd0) begin
            m_regs[wb_wd] <= wb_wdata;
            m_busy[wb_wd] <= 1'b0;
         end
         // Later NBA to the same element wins: a new load keeps the register pending.
         if (ld_issue && ld_rd != 5'd0) m_busy[ld_rd] <= 1'b1;
      end
   end

   function automatic logic [31:0] model_read(input logic re, input logic [4:0] a);
      if (rst || !re || a == 5'd0) return 32'h0;
      if (wb_wreg && wb_wd == a)   return wb_wdata;
      return m_regs[a];
   endfunction

   function automatic logic model_wait(input logic re, input logic [4:0] a);
      if (rst || !re || a == 5'd0) return 1'b0;
      if (wb_wreg && wb_wd == a)   return 1'b0;
      return m_busy[a];
   endfunction

   always @(negedge clk) begin
      if (m_valid) begin
         check("model_rdata1", rdata1, model_read(re1, raddr1));
         check("model_rdata2", rdata2, model_read(re2, raddr2));
         check("model_stall", {31'b0, stall_req},
               {31'b0, model_wait(re1, raddr1) || model_wait(re2, raddr2)});
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      wb_wreg = 1'b0; wb_wd = 5'd0; wb_wdata = 32'h0;
      re1 = 1'b0; raddr1 = 5'd0; re2 = 1'b0; raddr2 = 5'd0;
      ld_issue = 1'b0; ld_rd = 5'd0;
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      next_cycle();
      // Outputs stay quiet during reset even with live traffic on the inputs.
      wb_wreg = 1'b1; wb_wd = 5'd5; wb_wdata = 32'hFFFF_0000;
      re1 = 1'b1; raddr1 = 5'd5; ld_issue = 1'b1; ld_rd = 5'd5;
      #3 check("rst_gates_rdata1", rdata1, 32'h0);
      next_cycle();

      rst = 1'b0;
      idle_inputs();
      re1 = 1'b1; raddr1 = 5'd5; re2 = 1'b1; raddr2 = 5'd31;
      #3 check("reset_rdata1", rdata1, 32'h0);
      check("reset_rdata2", rdata2, 32'h0);
      check("reset_stall", {31'b0, stall_req}, 32'h0);

      next_cycle();
      wb_wreg = 1'b1; wb_wd = 5'd3; wb_wdata = 32'hDEAD_BEEF; raddr1 = 5'd3;
      #3 check("bypass_x3", rdata1, 32'hDEAD_BEEF);
      next_cycle();
      wb_wreg = 1'b0;
      #3 check("array_x3", rdata1, 32'hDEAD_BEEF);

      next_cycle();
      wb_wreg = 1'b1; wb_wd = 5'd0; wb_wdata = 32'h1234_5678; raddr1 = 5'd0;
      #3 check("x0_write_cycle", rdata1, 32'h0);
      next_cycle();
      wb_wreg = 1'b0;
      #3 check("x0_after_write", rdata1, 32'h0);

      next_cycle();
      ld_issue = 1'b1; ld_rd = 5'd7;
      #3 check("ld_issue_no_same_cycle_stall", {31'b0, stall_req}, 32'h0);
      next_cycle();
      ld_issue = 1'b0; raddr2 = 5'd7;
      #3 check("load_use_stall", {31'b0, stall_req}, 32'h1);
      next_cycle();
      #3 check("load_use_stall_hold", {31'b0, stall_req}, 32'h1);
      next_cycle();
      wb_wreg = 1'b1; wb_wd = 5'd7; wb_wdata = 32'h55;
      #3 check("wb_releases_stall", {31'b0, stall_req}, 32'h0);
      check("wb_bypass_x7", rdata2, 32'h55);
      next_cycle();
      wb_wreg = 1'b0;
      #3 check("x7_after_wb", rdata2, 32'h55);

      next_cycle();
      ld_issue = 1'b1; ld_rd = 5'd9; wb_wreg = 1'b1; wb_wd = 5'd9; wb_wdata = 32'h99;
      next_cycle();
      idle_inputs();
      re1 = 1'b1; raddr1 = 5'd9;
      #3 check("set_wins_stall", {31'b0, stall_req}, 32'h1);
      check("set_wins_data", rdata1, 32'h99);

      // Set and clear on different indices both apply; ld_rd==0 is ignored.
      next_cycle();
      ld_issue = 1'b1; ld_rd = 5'd10; wb_wreg = 1'b1; wb_wd = 5'd9; wb_wdata = 32'hA9;
      next_cycle();
      idle_inputs();
      ld_issue = 1'b1; ld_rd = 5'd0;
      re1 = 1'b1; raddr1 = 5'd9; re2 = 1'b1; raddr2 = 5'd10;
      #3 check("diff_idx_x9", rdata1, 32'hA9);
      check("diff_idx_stall_x10", {31'b0, stall_req}, 32'h1);
      next_cycle();
      idle_inputs();
      re1 = 1'b1; raddr1 = 5'd0; re2 = 1'b1; raddr2 = 5'd9;
      #3 check("ld_x0_no_stall", {31'b0, stall_req}, 32'h0);

      // Both ports on the same index.
      next_cycle();
      raddr1 = 5'd3; raddr2 = 5'd3;
      #3 check("same_idx_p1", rdata1, 32'hDEAD_BEEF);
      check("same_idx_p2", rdata2, 32'hDEAD_BEEF);
      re2 = 1'b0;
      #1 check("re2_disabled", rdata2, 32'h0);

      next_cycle();
      idle_inputs();
      wb_wreg = 1'b1; wb_wd = 5'd4; wb_wdata = 32'h11; ld_issue = 1'b1; ld_rd = 5'd4;
      next_cycle();
      idle_inputs();
      re1 = 1'b1; raddr1 = 5'd4;
      #3 check("pre_reset_x4", rdata1, 32'h11);
      check("pre_reset_stall", {31'b0, stall_req}, 32'h1);
      next_cycle();
      rst = 1'b1;
      #3 check("in_reset_stall", {31'b0, stall_req}, 32'h0);
      check("in_reset_x4", rdata1, 32'h0);
      next_cycle();
      rst = 1'b0;
      #3 check("post_reset_x4", rdata1, 32'h0);
      check("post_reset_stall", {31'b0, stall_req}, 32'h0);

      next_cycle();
      next_cycle();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
